// File: rtl/cfg_seg_sequencer.sv
// Command sequencer: splits one config descriptor into bounded copy segments with an in-flight cap.
// Optional 4 KB page-boundary splitting is enabled by defining SEQ_BOUNDARY_4K_EN.
module cfg_seg_sequencer #(
    parameter int MAX_SEG   = 256,
    parameter int MAX_OUTST = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic [31:0] CFG_CMD,
    input  logic [31:0] CFG_SRC,
    input  logic [31:0] CFG_DEST,
    input  logic [31:0] CFG_LEN,
    output logic        SEG_VALID,
    input  logic        SEG_READY,
    output logic [31:0] SEG_SRC,
    output logic [31:0] SEG_DEST,
    output logic [12:0] SEG_LEN,
    output logic        SEG_LAST,
    input  logic        SEG_DONE,
    input  logic        SEG_ERR,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] MAX_SEG_C   = 32'(MAX_SEG);
    localparam logic [3:0]  MAX_OUTST_C = 4'(MAX_OUTST);

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        if (a < b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

`ifdef SEQ_BOUNDARY_4K_EN
    function automatic logic [31:0] page_room(input logic [11:0] off);
        return 32'd4096 - {20'd0, off};
    endfunction
`endif

    state_t      state_r, state_n_s;
    logic [3:0]  outst_r, outst_n_s;
    logic [31:0] rem_r, rem_n_s;
    logic [31:0] cur_src_r, src_n_s;
    logic [31:0] cur_dst_r, dst_n_s;
    logic        err_r, err_n_s;
    logic        seg_valid_r, seg_valid_n_s;
    logic [12:0] seg_len_r;
    logic        seg_last_r, seg_last_n_s;
    logic        cfg_ready_r;
    logic        busy_r;
    logic [31:0] seg_lim_s;
    logic        fire_s;
    logic        done_ok_s;
    logic        done_bad_s;
    logic        cmd_unused_s;

    assign cmd_unused_s = ^CFG_CMD[31:1];
    assign fire_s       = seg_valid_r & SEG_READY;
    assign done_ok_s    = SEG_DONE & (outst_r != 4'd0);
    assign done_bad_s   = SEG_DONE & (SEG_ERR | (outst_r == 4'd0));

    // Next-state: FSM, outstanding count, address/remaining datapath and sticky error
    always_comb begin
        state_n_s = state_r;
        rem_n_s   = rem_r;
        src_n_s   = cur_src_r;
        dst_n_s   = cur_dst_r;
        err_n_s   = err_r;

        // A completion arriving with nothing outstanding is dropped rather than underflowing
        case ({fire_s, done_ok_s})
            2'b10:   outst_n_s = outst_r + 4'd1;
            2'b01:   outst_n_s = outst_r - 4'd1;
            default: outst_n_s = outst_r;
        endcase

        case (state_r)
            ST_IDLE: begin
                if (CFG_VALID) begin
                    src_n_s = CFG_SRC;
                    dst_n_s = CFG_DEST;
                    rem_n_s = CFG_LEN;
                    err_n_s = 1'b0;
                    if (!CFG_CMD[0] || (CFG_LEN == 32'd0)) begin
                        state_n_s = ST_DRAIN;
                    end else begin
                        state_n_s = ST_ISSUE;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fire_s) begin
                    src_n_s = cur_src_r + {19'd0, seg_len_r};
                    dst_n_s = cur_dst_r + {19'd0, seg_len_r};
                    rem_n_s = rem_r - {19'd0, seg_len_r};
                    if (seg_last_r) begin
                        state_n_s = ST_DRAIN;
                    end else begin
                        state_n_s = ST_ISSUE;
                    end
                end else begin
                    state_n_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (outst_n_s == 4'd0) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase

        // Error set wins over the clear on accept so a stray completion is never lost
        if (done_bad_s) begin
            err_n_s = 1'b1;
        end else begin
            err_n_s = err_n_s;
        end
    end

    // Segment request for the next cycle, computed from next-state so outputs can be registered
    always_comb begin
        seg_lim_s = min_u32(rem_n_s, MAX_SEG_C);
`ifdef SEQ_BOUNDARY_4K_EN
        seg_lim_s = min_u32(seg_lim_s, page_room(src_n_s[11:0]));
        seg_lim_s = min_u32(seg_lim_s, page_room(dst_n_s[11:0]));
`endif
        seg_valid_n_s = (state_n_s == ST_ISSUE) && (outst_n_s < MAX_OUTST_C);
        seg_last_n_s  = (state_n_s == ST_ISSUE) && (rem_n_s == seg_lim_s);
    end

    // State, datapath and registered outputs
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r     <= ST_IDLE;
            outst_r     <= 4'd0;
            rem_r       <= 32'd0;
            cur_src_r   <= 32'd0;
            cur_dst_r   <= 32'd0;
            err_r       <= 1'b0;
            seg_valid_r <= 1'b0;
            seg_len_r   <= 13'd0;
            seg_last_r  <= 1'b0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            outst_r     <= outst_n_s;
            rem_r       <= rem_n_s;
            cur_src_r   <= src_n_s;
            cur_dst_r   <= dst_n_s;
            err_r       <= err_n_s;
            seg_valid_r <= seg_valid_n_s;
            seg_len_r   <= seg_lim_s[12:0];
            seg_last_r  <= seg_last_n_s;
            cfg_ready_r <= (state_n_s == ST_IDLE);
            busy_r      <= (state_n_s != ST_IDLE);
        end
    end

    assign CFG_READY = cfg_ready_r;
    assign BUSY      = busy_r;
    assign ERR       = err_r;
    assign SEG_VALID = seg_valid_r;
    assign SEG_SRC   = cur_src_r;
    assign SEG_DEST  = cur_dst_r;
    assign SEG_LEN   = seg_len_r;
    assign SEG_LAST  = seg_last_r;

endmodule

// File: tb/tb_cfg_seg_sequencer.sv
// Bench for cfg_seg_sequencer: vector table, directed corner sequences and randomized commands
// checked against a queue-based segment model; follows SEQ_BOUNDARY_4K_EN like the design.
module tb_cfg_seg_sequencer;

    localparam int MAX_SEG   = 256;
    localparam int MAX_OUTST = 2;
`ifdef SEQ_BOUNDARY_4K_EN
    localparam bit B4K = 1'b1;
`else
    localparam bit B4K = 1'b0;
`endif

    logic        ACLK;
    logic        ARESETN;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [31:0] CFG_CMD, CFG_SRC, CFG_DEST, CFG_LEN;
    logic        SEG_VALID, SEG_READY;
    logic [31:0] SEG_SRC, SEG_DEST;
    logic [12:0] SEG_LEN;
    logic        SEG_LAST, SEG_DONE, SEG_ERR, BUSY, ERR;

    cfg_seg_sequencer #(.MAX_SEG(MAX_SEG), .MAX_OUTST(MAX_OUTST)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_CMD(CFG_CMD),
        .CFG_SRC(CFG_SRC), .CFG_DEST(CFG_DEST), .CFG_LEN(CFG_LEN),
        .SEG_VALID(SEG_VALID), .SEG_READY(SEG_READY), .SEG_SRC(SEG_SRC),
        .SEG_DEST(SEG_DEST), .SEG_LEN(SEG_LEN), .SEG_LAST(SEG_LAST),
        .SEG_DONE(SEG_DONE), .SEG_ERR(SEG_ERR), .BUSY(BUSY), .ERR(ERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        logic        last;
    } seg_t;

    typedef struct {
        logic        go;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        int          nseg;
        int          len0;
        int          lenl;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    seg_t exp_q[$];
    bit   m_act, m_drn, m_err;
    int   m_outst;
    bit   auto_eng = 1'b0;
    int   rdy_pct, done_pct, err_pct;
    int   cmd_nseg, cmd_first_len, cmd_last_len;
    logic [31:0] cmd_first_src;
    bit   prev_hold = 1'b0;
    seg_t prev_seg;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected segment list straight from the splitting rules
    task automatic build_segs(input logic [31:0] src_i, input logic [31:0] dst_i, input longint len);
        longint      rem = len;
        longint      n;
        longint      room;
        logic [31:0] src = src_i;
        logic [31:0] dst = dst_i;
        seg_t        s;
        while (rem > 0) begin
            n = rem;
            if (n > longint'(MAX_SEG)) n = longint'(MAX_SEG);
            if (B4K) begin
                room = 64'd4096 - {52'd0, src[11:0]};
                if (n > room) n = room;
                room = 64'd4096 - {52'd0, dst[11:0]};
                if (n > room) n = room;
            end
            s.src  = src;
            s.dst  = dst;
            s.len  = int'(n);
            rem    = rem - n;
            s.last = (rem == 0);
            exp_q.push_back(s);
            src = src + n[31:0];
            dst = dst + n[31:0];
        end
    endtask

    // One clock: drive engine (auto mode), check handshake, advance model, check outputs
    task automatic cycle();
        bit   acc, fire, done, derr, rst;
        seg_t s;
        if (auto_eng) begin
            SEG_READY = ($urandom_range(99) < rdy_pct);
            if (m_outst > 0 && $urandom_range(99) < done_pct) begin
                SEG_DONE = 1'b1;
                SEG_ERR  = ($urandom_range(99) < err_pct);
            end else begin
                SEG_DONE = 1'b0;
                SEG_ERR  = 1'b0;
            end
        end
        rst  = !ARESETN;
        acc  = (CFG_VALID === 1'b1) && (CFG_READY === 1'b1);
        fire = (SEG_VALID === 1'b1) && (SEG_READY === 1'b1);
        done = SEG_DONE;
        derr = SEG_ERR;
        if (prev_hold && SEG_VALID === 1'b1) begin
            check("hold_src", SEG_SRC, prev_seg.src);
            check("hold_len", 32'(SEG_LEN), prev_seg.len);
        end
        prev_hold    = (SEG_VALID === 1'b1) && !SEG_READY;
        prev_seg.src = SEG_SRC;
        prev_seg.len = int'(SEG_LEN);
        if (fire) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL seg_unexpected: got segment src=0x%0h len=%0d expected none", SEG_SRC, SEG_LEN);
            end else begin
                s = exp_q.pop_front();
                check("seg_src", SEG_SRC, s.src);
                check("seg_dest", SEG_DEST, s.dst);
                check("seg_len", 32'(SEG_LEN), s.len);
                check("seg_last", 32'(SEG_LAST), 32'(s.last));
            end
            if (cmd_nseg == 0) begin
                cmd_first_len = int'(SEG_LEN);
                cmd_first_src = SEG_SRC;
            end
            cmd_last_len = int'(SEG_LEN);
            cmd_nseg++;
        end
        @(posedge ACLK);
        if (rst) begin
            exp_q.delete();
            m_act = 1'b0; m_drn = 1'b0; m_err = 1'b0; m_outst = 0;
        end else begin
            if (acc) m_err = 1'b0;
            if (done && (derr || m_outst == 0)) m_err = 1'b1;
            m_outst = m_outst + (fire ? 1 : 0) - ((done && m_outst > 0) ? 1 : 0);
            if (!m_act) begin
                if (acc) begin
                    check("stale_segments", 32'(exp_q.size()), 32'd0);
                    exp_q.delete();
                    if (CFG_CMD[0]) build_segs(CFG_SRC, CFG_DEST, longint'(CFG_LEN));
                    m_act = 1'b1;
                    m_drn = (exp_q.size() == 0);
                    cmd_nseg = 0; cmd_first_len = 0; cmd_last_len = 0; cmd_first_src = 32'd0;
                end
            end else if (!m_drn) begin
                if (fire && exp_q.size() == 0) m_drn = 1'b1;
            end else if (m_outst == 0) begin
                m_act = 1'b0;
            end
        end
        @(negedge ACLK);
        check("cfg_ready", 32'(CFG_READY), 32'(!m_act));
        check("busy", 32'(BUSY), 32'(m_act));
        check("seg_valid", 32'(SEG_VALID), 32'(m_act && !m_drn && m_outst < MAX_OUTST));
        check("err", 32'(ERR), 32'(m_err));
    endtask

    task automatic wait_ready(input int budget);
        int i = 0;
        while (CFG_READY !== 1'b1 && i < budget) begin
            cycle();
            i++;
        end
        check("ready_timeout", 32'(CFG_READY), 32'd1);
    endtask

    task automatic send_cmd(input logic go, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len);
        int i = 0;
        bit a;
        CFG_CMD   = {31'd0, go};
        CFG_SRC   = src;
        CFG_DEST  = dst;
        CFG_LEN   = len;
        CFG_VALID = 1'b1;
        do begin
            a = (CFG_READY === 1'b1);
            cycle();
            i++;
        end while (!a && i < 3000);
        CFG_VALID = 1'b0;
        check("accept_timeout", 32'(a), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 32'h0000_1000, 32'h0000_2000, 32'd64,   1, 64, 64};
        vt[1] = '{1'b1, 32'h0000_0000, 32'h0001_0000, 32'd1000, 4, 256, 232};
        vt[2] = '{1'b1, 32'h0000_0FF0, 32'h0000_3000, 32'd64,
                  B4K ? 2 : 1, B4K ? 16 : 64, B4K ? 48 : 64};
        vt[3] = '{1'b0, 32'h0000_0100, 32'h0000_0200, 32'd100,  0, 0, 0};
        vt[4] = '{1'b1, 32'h0000_0100, 32'h0000_0200, 32'd0,    0, 0, 0};
        vt[5] = '{1'b1, 32'h0000_0100, 32'h0000_2F80, 32'd256,
                  B4K ? 2 : 1, B4K ? 128 : 256, B4K ? 128 : 256};
        vt[6] = '{1'b1, 32'hFFFF_FF00, 32'h0000_0000, 32'd512,  2, 256, 256};
        vt[7] = '{1'b1, 32'h0000_0040, 32'h0000_0080, 32'd257,  2, 256, 1};

        ARESETN = 1'b0; CFG_VALID = 1'b0; CFG_CMD = 32'd0; CFG_SRC = 32'd0;
        CFG_DEST = 32'd0; CFG_LEN = 32'd0; SEG_READY = 1'b0; SEG_DONE = 1'b0; SEG_ERR = 1'b0;
        m_act = 1'b0; m_drn = 1'b0; m_err = 1'b0; m_outst = 0;
        cmd_nseg = 0; cmd_first_len = 0; cmd_last_len = 0; cmd_first_src = 32'd0;
        @(negedge ACLK);
        cycle();
        cycle();
        check("reset_seg_last", 32'(SEG_LAST), 32'd0);
        ARESETN = 1'b1;
        cycle();

        // Vector table
        auto_eng = 1'b1; rdy_pct = 100; done_pct = 50; err_pct = 0;
        for (int i = 0; i < 8; i++) begin
            send_cmd(vt[i].go, vt[i].src, vt[i].dst, vt[i].len);
            wait_ready(300);
            check($sformatf("vec%0d_nseg", i), 32'(cmd_nseg), 32'(vt[i].nseg));
            check($sformatf("vec%0d_len0", i), 32'(cmd_first_len), 32'(vt[i].len0));
            check($sformatf("vec%0d_lenl", i), 32'(cmd_last_len), 32'(vt[i].lenl));
            check($sformatf("vec%0d_src0", i), cmd_first_src, (vt[i].nseg > 0) ? vt[i].src : 32'd0);
            check($sformatf("vec%0d_err", i), 32'(ERR), 32'd0);
        end
        auto_eng = 1'b0; SEG_DONE = 1'b0; SEG_ERR = 1'b0;

        // Single segment: CFG_READY one cycle after SEG_DONE
        SEG_READY = 1'b1;
        send_cmd(1'b1, 32'h1000, 32'h2000, 32'd64);
        check("single_valid", 32'(SEG_VALID), 32'd1);
        check("single_len", 32'(SEG_LEN), 32'd64);
        check("single_last", 32'(SEG_LAST), 32'd1);
        cycle();
        repeat (3) cycle();
        check("single_ready_wait", 32'(CFG_READY), 32'd0);
        SEG_DONE = 1'b1;
        cycle();
        SEG_DONE = 1'b0;
        check("single_ready_after_done", 32'(CFG_READY), 32'd1);
        check("single_err", 32'(ERR), 32'd0);

        // No-op commands: ready returns at T+2, nothing issued
        for (int k = 0; k < 2; k++) begin
            send_cmd(k == 0 ? 1'b0 : 1'b1, 32'h40, 32'h80, k == 0 ? 32'd100 : 32'd0);
            check("noop_t1_ready", 32'(CFG_READY), 32'd0);
            check("noop_t1_valid", 32'(SEG_VALID), 32'd0);
            cycle();
            check("noop_t2_ready", 32'(CFG_READY), 32'd1);
            check("noop_nseg", 32'(cmd_nseg), 32'd0);
        end

        // Flow control: cap of two in flight, one completion releases one segment
        send_cmd(1'b1, 32'h0, 32'h8000, 32'd2048);
        repeat (10) cycle();
        check("flow_nseg_capped", 32'(cmd_nseg), 32'd2);
        check("flow_valid_low", 32'(SEG_VALID), 32'd0);
        SEG_DONE = 1'b1;
        cycle();
        SEG_DONE = 1'b0;
        repeat (5) cycle();
        check("flow_nseg_released", 32'(cmd_nseg), 32'd3);
        auto_eng = 1'b1; done_pct = 50;
        wait_ready(300);
        auto_eng = 1'b0; SEG_DONE = 1'b0; SEG_ERR = 1'b0; SEG_READY = 1'b1;
        check("flow_nseg_total", 32'(cmd_nseg), 32'd8);

        // Error on segment 2 of 4: remaining segments still issued, ERR sticky until next accept
        send_cmd(1'b1, 32'h0, 32'h4000, 32'd1024);
        for (int k = 0; k < 4; k++) begin
            repeat (2) cycle();
            SEG_DONE = 1'b1;
            SEG_ERR  = (k == 1);
            cycle();
            SEG_DONE = 1'b0;
            SEG_ERR  = 1'b0;
            if (k == 1) check("err_set", 32'(ERR), 32'd1);
        end
        wait_ready(20);
        check("err_nseg", 32'(cmd_nseg), 32'd4);
        check("err_sticky", 32'(ERR), 32'd1);
        send_cmd(1'b0, 32'h0, 32'h0, 32'd0);
        check("err_clear_on_accept", 32'(ERR), 32'd0);
        wait_ready(10);

        // Spurious completion while idle
        SEG_DONE = 1'b1;
        cycle();
        SEG_DONE = 1'b0;
        check("spurious_err", 32'(ERR), 32'd1);
        send_cmd(1'b0, 32'h0, 32'h0, 32'd0);
        wait_ready(10);

        // Reset during ISSUE, then a stale completion from the engine
        send_cmd(1'b1, 32'h0, 32'h0, 32'd2048);
        cycle();
        SEG_READY = 1'b0;
        cycle();
        ARESETN = 1'b0;
        cycle();
        check("rst_cfg_ready", 32'(CFG_READY), 32'd1);
        check("rst_seg_valid", 32'(SEG_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_seg_last", 32'(SEG_LAST), 32'd0);
        ARESETN = 1'b1;
        cycle();
        SEG_DONE = 1'b1;
        cycle();
        SEG_DONE = 1'b0;
        check("inflight_done_err", 32'(ERR), 32'd1);

        // Randomized commands against the model
        auto_eng = 1'b1; rdy_pct = 70; done_pct = 35; err_pct = 5;
        for (int c = 0; c < 40; c++) begin
            logic [31:0] rs, rd, rl;
            logic        rg;
            rg = ($urandom_range(9) != 0);
            rl = ($urandom_range(9) == 0) ? 32'd0 : 32'($urandom_range(1500, 1));
            rs = $urandom;
            rd = $urandom;
            if ($urandom_range(1) == 1) rs[11:0] = 12'hF00 | 12'($urandom_range(255));
            if ($urandom_range(1) == 1) rd[11:0] = 12'hF00 | 12'($urandom_range(255));
            send_cmd(rg, rs, rd, rl);
        end
        wait_ready(3000);
        auto_eng = 1'b0; SEG_DONE = 1'b0; SEG_ERR = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
